hop_sprite_ctrl: RTL and testbench
==================================

// Module: hop_sprite_ctrl
// PURPOSE
//  Next-generation player-sprite controller for the VGA game layer. Moves a rectangular
//  sprite in discrete hops of HOP_DIS pixels, animated HOP_STEP pixels per animation tick.
//  Adds button edge detection, display-bound rejection, a lives/respawn/game-over state
//  machine and a forward-progress score. Sits between the button debouncers and the
//  pixel-compare/draw logic, alongside the obstacle modules.
// PARAMETERS
//  H_WIDTH    11   half sprite width, pixels
//  H_HEIGHT   11   half sprite height, pixels
//  IX         320  spawn centre x
//  IY         460  spawn centre y
//  D_WIDTH    640  display width
//  D_HEIGHT   480  display height
//  HOP_DIS    48   pixels per hop; must be a multiple of HOP_STEP
//  HOP_STEP   4    pixels moved per animation tick during a hop
//  LIVES      3    lives at reset, 1..7
//  RESPAWN    30   ticks spent in DEAD before control returns
// PORTS
//  i_clk        in   1   base clock
//  i_rst        in   1   synchronous, active-high reset
//  i_ani_stb    in   1   animation strobe, one-cycle pulse per frame
//  i_animate    in   1   animation enable; tick = i_ani_stb & i_animate
//  i_btn_n      in   4   active-low buttons {up,down,left,right} = [3:0]
//  i_dead       in   1   collision pulse, any cycle
//  o_x1,o_x2    out  12  sprite left/right edge = x -/+ H_WIDTH
//  o_y1,o_y2    out  12  sprite top/bottom edge = y -/+ H_HEIGHT
//  o_busy       out  1   high in HOP or DEAD
//  o_lives      out  3   remaining lives
//  o_game_over  out  1   high in OVER
//  o_score      out  16  completed up-hops, saturating
// BEHAVIOUR
//  - All state changes occur only on a tick, except i_rst and dead-latch capture.
//  - Reset (any state, mid-hop included): x=IX, y=IY, state IDLE, lives=LIVES, score=0,
//    dead latch=0, btn sample=0, step count=0; o_busy=0, o_game_over=0.
//  - Buttons: btn=~i_btn_n; sampled each tick into btn_q. A press is btn & ~btn_q
//    (rising edge across ticks). Holding a button yields exactly one hop.
//  - Priority when several new presses occur on one tick: up > down > left > right.
//  - Dead latch: set on any cycle with i_dead=1; cleared when consumed on a tick.
//  - States:
//    IDLE: on tick, if dead latch -> DIE. Else on press, bound check: target edge must
//      stay within [0, D_WIDTH-1] x [0, D_HEIGHT-1] (up: y-HOP_DIS-H_HEIGHT >= 0; down:
//      y+HOP_DIS+H_HEIGHT <= D_HEIGHT-1; same for x). Pass -> HOP with dir latched and
//      step count=0. Fail -> stay IDLE, no movement.
//    HOP: each tick move HOP_STEP in dir, step count+1; the tick reaching HOP_DIS/HOP_STEP
//      steps returns to IDLE the same tick (first step on the tick after acceptance).
//      New presses ignored (btn_q still updates). Up-hop completion: score+1, sat 16'hFFFF.
//      Dead latch on a tick -> DIE, hop aborted, no step that tick.
//    DIE (action, same tick): x=IX, y=IY; lives-1. If lives was 1 -> OVER with lives=0,
//      else -> DEAD with respawn counter=0.
//    DEAD: dead latch is cleared and ignored; counter+1 per tick; after RESPAWN ticks -> IDLE.
//    OVER: position held at spawn; all inputs ignored until i_rst.
//  - Widths: x,y 12-bit unsigned; bound checks use 13-bit signed compare (no wrap).
//  - Outputs are registered-state combinational decodes; zero-latency from x/y.
// TESTING
//  1 Reset, up pressed one tick then held -> 12 ticks of y-4, y=412; o_busy high
//    exactly 12 ticks; o_score=1; holding gives no second hop.
//  2 Spawn y=460, press down -> rejected (471+48>479), y stays 460, o_busy=0.
//  3 Up and right rising on same tick -> up hop only, x stays 320.
//  4 i_dead pulse between ticks on hop step 5 -> next tick x=320,y=460, lives 3->2,
//    o_busy high 30 ticks, then a press hops normally.
//  5 Three deaths -> o_lives=0, o_game_over=1, presses ignored; i_rst restores lives=3.
//  6 i_animate=0 with strobes and presses -> no movement; i_rst mid-hop -> spawn, IDLE.

Source files
------------

// File: rtl/hop_sprite_if.sv
// Sprite controller bus: animation/button/collision inputs and sprite state outputs.
interface hop_sprite_if;
  logic        i_ani_stb;
  logic        i_animate;
  logic [3:0]  i_btn_n;
  logic        i_dead;
  logic [11:0] o_x1;
  logic [11:0] o_x2;
  logic [11:0] o_y1;
  logic [11:0] o_y2;
  logic        o_busy;
  logic [2:0]  o_lives;
  logic        o_game_over;
  logic [15:0] o_score;

  modport master (
    output i_ani_stb, i_animate, i_btn_n, i_dead,
    input  o_x1, o_x2, o_y1, o_y2, o_busy, o_lives, o_game_over, o_score
  );

  modport slave (
    input  i_ani_stb, i_animate, i_btn_n, i_dead,
    output o_x1, o_x2, o_y1, o_y2, o_busy, o_lives, o_game_over, o_score
  );
endinterface

// File: rtl/hop_sprite_ctrl.sv
// Player-sprite controller: edge-detected button hops animated per tick,
// display-bound rejection, lives/respawn/game-over FSM and up-hop score.
module hop_sprite_ctrl #(
  parameter int H_WIDTH  = 11,
  parameter int H_HEIGHT = 11,
  parameter int IX       = 320,
  parameter int IY       = 460,
  parameter int D_WIDTH  = 640,
  parameter int D_HEIGHT = 480,
  parameter int HOP_DIS  = 48,
  parameter int HOP_STEP = 4,
  parameter int LIVES    = 3,
  parameter int RESPAWN  = 30
) (
  input logic         i_clk,
  input logic         i_rst,
  hop_sprite_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HOP, DEAD, OVER} state_t;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  localparam logic [11:0] IX12   = 12'(IX);
  localparam logic [11:0] IY12   = 12'(IY);
  localparam logic [11:0] HW12   = 12'(H_WIDTH);
  localparam logic [11:0] HH12   = 12'(H_HEIGHT);
  localparam logic [11:0] STEP12 = 12'(HOP_STEP);
  localparam logic [7:0]  STEPS  = 8'(HOP_DIS / HOP_STEP);
  localparam logic [15:0] RSP    = 16'(RESPAWN);
  localparam logic [2:0]  LIVES3 = 3'(LIVES);

  // Signed 13-bit bound constants so the edge checks cannot wrap.
  localparam logic signed [12:0] S_HD   = 13'(HOP_DIS);
  localparam logic signed [12:0] S_HW   = 13'(H_WIDTH);
  localparam logic signed [12:0] S_HH   = 13'(H_HEIGHT);
  localparam logic signed [12:0] S_XMAX = 13'(D_WIDTH - 1);
  localparam logic signed [12:0] S_YMAX = 13'(D_HEIGHT - 1);
  localparam logic signed [12:0] S_ZERO = 13'sd0;

  state_t      state, state_n;
  dir_t        dir, dir_n;
  logic [11:0] x, x_n, y, y_n;
  logic [2:0]  lives, lives_n;
  logic [15:0] score, score_n;
  logic [15:0] rcnt, rcnt_n;
  logic [7:0]  step, step_n;
  logic [3:0]  btn_q, btn_q_n;
  logic        dead_q, dead_q_n;

  logic        tick, dead_hit;
  logic [3:0]  btn, press;
  logic signed [12:0] xs, ys;
  logic        up_ok, down_ok, left_ok, right_ok;

  assign tick     = bus.i_ani_stb & bus.i_animate;
  assign btn      = ~bus.i_btn_n;
  assign press    = btn & ~btn_q;
  // A collision on the tick cycle itself counts as already latched.
  assign dead_hit = dead_q | bus.i_dead;

  assign xs       = signed'({1'b0, x});
  assign ys       = signed'({1'b0, y});
  assign up_ok    = (ys - S_HD - S_HH) >= S_ZERO;
  assign down_ok  = (ys + S_HD + S_HH) <= S_YMAX;
  assign left_ok  = (xs - S_HD - S_HW) >= S_ZERO;
  assign right_ok = (xs + S_HD + S_HW) <= S_XMAX;

  // Register all controller state; reset returns to spawn, IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      dir    <= D_UP;
      x      <= IX12;
      y      <= IY12;
      lives  <= LIVES3;
      score  <= '0;
      rcnt   <= '0;
      step   <= '0;
      btn_q  <= '0;
      dead_q <= 1'b0;
    end else begin
      state  <= state_n;
      dir    <= dir_n;
      x      <= x_n;
      y      <= y_n;
      lives  <= lives_n;
      score  <= score_n;
      rcnt   <= rcnt_n;
      step   <= step_n;
      btn_q  <= btn_q_n;
      dead_q <= dead_q_n;
    end
  end

  // Next-state, movement, lives and score; DIE is an action folded into the tick.
  always_comb begin
    state_n  = state;
    dir_n    = dir;
    x_n      = x;
    y_n      = y;
    lives_n  = lives;
    score_n  = score;
    rcnt_n   = rcnt;
    step_n   = step;
    btn_q_n  = tick ? btn : btn_q;
    dead_q_n = (state == OVER) ? 1'b0 : (tick ? 1'b0 : (dead_q | bus.i_dead));

    if (tick) begin
      unique case (state)
        IDLE, HOP: begin
          if (dead_hit) begin
            x_n    = IX12;
            y_n    = IY12;
            step_n = '0;
            if (lives == 3'd1) begin
              lives_n = '0;
              state_n = OVER;
            end else begin
              lives_n = lives - 3'd1;
              rcnt_n  = '0;
              state_n = DEAD;
            end
          end else if (state == IDLE) begin
            if (press[3]) begin
              if (up_ok) begin state_n = HOP; dir_n = D_UP; step_n = '0; end
            end else if (press[2]) begin
              if (down_ok) begin state_n = HOP; dir_n = D_DOWN; step_n = '0; end
            end else if (press[1]) begin
              if (left_ok) begin state_n = HOP; dir_n = D_LEFT; step_n = '0; end
            end else if (press[0]) begin
              if (right_ok) begin state_n = HOP; dir_n = D_RIGHT; step_n = '0; end
            end
          end else begin
            unique case (dir)
              D_UP:    y_n = y - STEP12;
              D_DOWN:  y_n = y + STEP12;
              D_LEFT:  x_n = x - STEP12;
              D_RIGHT: x_n = x + STEP12;
            endcase
            step_n = step + 8'd1;
            if (step + 8'd1 == STEPS) begin
              state_n = IDLE;
              step_n  = '0;
              if (dir == D_UP && score != 16'hFFFF) score_n = score + 16'd1;
            end
          end
        end
        DEAD: begin
          rcnt_n = rcnt + 16'd1;
          if (rcnt + 16'd1 == RSP) state_n = IDLE;
        end
        OVER: ;
      endcase
    end
  end

  assign bus.o_x1        = x - HW12;
  assign bus.o_x2        = x + HW12;
  assign bus.o_y1        = y - HH12;
  assign bus.o_y2        = y + HH12;
  assign bus.o_busy      = (state == HOP) || (state == DEAD);
  assign bus.o_lives     = lives;
  assign bus.o_game_over = (state == OVER);
  assign bus.o_score     = score;

endmodule

// File: tb/tb_hop_sprite_ctrl.sv
// Directed bench for hop_sprite_ctrl with hand-computed expectations.
module tb_hop_sprite_ctrl;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   busycnt;

  hop_sprite_if bus ();

  hop_sprite_ctrl dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One animation tick; returns at the following negedge so outputs are settled.
  task automatic tick();
    @(negedge i_clk);
    bus.i_ani_stb = 1'b1;
    @(negedge i_clk);
    bus.i_ani_stb = 1'b0;
  endtask

  task automatic pulse_dead();
    @(negedge i_clk);
    bus.i_dead = 1'b1;
    @(negedge i_clk);
    bus.i_dead = 1'b0;
  endtask

  task automatic pos(input string tag, input int x1, input int y1);
    chk({tag, "_x1"}, int'(bus.o_x1), x1);
    chk({tag, "_x2"}, int'(bus.o_x2), x1 + 22);
    chk({tag, "_y1"}, int'(bus.o_y1), y1);
    chk({tag, "_y2"}, int'(bus.o_y2), y1 + 22);
  endtask

  initial begin
    bus.i_ani_stb = 1'b0;
    bus.i_animate = 1'b1;
    bus.i_btn_n   = 4'hF;
    bus.i_dead    = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;

    // reset state
    pos("rst", 309, 449);
    chk("rst_busy",  int'(bus.o_busy), 0);
    chk("rst_lives", int'(bus.o_lives), 3);
    chk("rst_over",  int'(bus.o_game_over), 0);
    chk("rst_score", int'(bus.o_score), 0);

    // down at spawn rejected: 460+48+11 > 479
    bus.i_btn_n = 4'b1011;
    tick();
    chk("down_rej_busy", int'(bus.o_busy), 0);
    chk("down_rej_y1", int'(bus.o_y1), 449);
    bus.i_btn_n = 4'hF;
    tick();

    // up hop, held: 12 steps of 4, one hop only
    bus.i_btn_n = 4'b0111;
    tick();
    chk("up_acc_busy", int'(bus.o_busy), 1);
    chk("up_acc_y1", int'(bus.o_y1), 449);
    busycnt = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.o_busy) busycnt++;
    end
    chk("up_busy_ticks", busycnt, 12);
    pos("up_done", 309, 401);
    chk("up_score", int'(bus.o_score), 1);
    repeat (3) tick();
    chk("hold_busy", int'(bus.o_busy), 0);
    chk("hold_y1", int'(bus.o_y1), 401);
    bus.i_btn_n = 4'hF;
    tick();

    // up and right on the same tick: up wins
    bus.i_btn_n = 4'b0110;
    repeat (13) tick();
    pos("prio", 309, 353);
    chk("prio_score", int'(bus.o_score), 2);
    bus.i_btn_n = 4'hF;
    tick();

    // death during hop step 5
    bus.i_btn_n = 4'b0111;
    tick();
    bus.i_btn_n = 4'hF;
    repeat (5) tick();
    chk("mid_y1", int'(bus.o_y1), 353 - 20);
    pulse_dead();
    tick();
    pos("die", 309, 449);
    chk("die_lives", int'(bus.o_lives), 2);
    chk("die_busy", int'(bus.o_busy), 1);
    chk("die_score", int'(bus.o_score), 2);
    busycnt = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.o_busy) busycnt++;
    end
    chk("dead_busy_ticks", busycnt, 30);
    chk("respawn_busy", int'(bus.o_busy), 0);
    bus.i_btn_n = 4'b1101;
    repeat (13) tick();
    pos("left_hop", 261, 449);
    bus.i_btn_n = 4'hF;
    tick();

    // two more deaths -> game over
    pulse_dead();
    tick();
    chk("d2_lives", int'(bus.o_lives), 1);
    pulse_dead();
    repeat (30) tick();
    chk("d2_idle", int'(bus.o_busy), 0);
    chk("d2_lives_hold", int'(bus.o_lives), 1);
    pulse_dead();
    tick();
    chk("over_lives", int'(bus.o_lives), 0);
    chk("over_flag", int'(bus.o_game_over), 1);
    pos("over", 309, 449);
    bus.i_btn_n = 4'b0111;
    repeat (3) tick();
    chk("over_busy", int'(bus.o_busy), 0);
    chk("over_y1", int'(bus.o_y1), 449);
    bus.i_btn_n = 4'hF;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst2_lives", int'(bus.o_lives), 3);
    chk("rst2_over", int'(bus.o_game_over), 0);
    chk("rst2_score", int'(bus.o_score), 0);

    // animation disabled: strobes do nothing
    bus.i_animate = 1'b0;
    bus.i_btn_n   = 4'b0111;
    repeat (4) tick();
    chk("noani_busy", int'(bus.o_busy), 0);
    chk("noani_y1", int'(bus.o_y1), 449);
    bus.i_animate = 1'b1;
    repeat (4) tick();
    chk("ani_mid_y1", int'(bus.o_y1), 449 - 12);
    chk("ani_mid_busy", int'(bus.o_busy), 1);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    pos("rst_mid", 309, 449);
    chk("rst_mid_busy", int'(bus.o_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
